// File: rtl/vec_alu_sequencer_if.sv
// vec_alu_sequencer_if: instruction, register-file, lane-drive and status signals of the sequencer.
interface vec_alu_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int VLEN  = 16,
   parameter int RAW   = 4
);
   localparam int BEATS = VLEN / LANES;
   localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
   logic req_valid, req_ready, req_scalar;
   logic [2:0] req_opcode;
   logic [RAW-1:0] req_vd, req_va, req_vb;
   logic [WIDTH-1:0] req_imm;
   logic rd_en;
   logic [RAW-1:0] rd_va, rd_vb;
   logic [BW-1:0] rd_beat;
   logic [LANES*WIDTH-1:0] rd_data_a, rd_data_b;
   logic [2:0] alu_opcode;
   logic alu_scalar;
   logic [LANES*WIDTH-1:0] alu_a, alu_b, alu_c, alu_result;
   logic [LANES*4-1:0] alu_flags;
   logic wr_en;
   logic [RAW-1:0] wr_vd;
   logic [BW-1:0] wr_beat;
   logic [LANES*WIDTH-1:0] wr_data;
   logic [LANES-1:0] wr_mask;
   logic busy, done, err;
   logic [3:0] flags_out;
   modport master (
      input  req_valid, req_opcode, req_scalar, req_vd, req_va, req_vb, req_imm,
             rd_data_a, rd_data_b, alu_result, alu_flags,
      output req_ready, rd_en, rd_va, rd_vb, rd_beat, alu_opcode, alu_scalar, alu_a, alu_b, alu_c,
             wr_en, wr_vd, wr_beat, wr_data, wr_mask, busy, done, err, flags_out
   );
   modport slave (
      output req_valid, req_opcode, req_scalar, req_vd, req_va, req_vb, req_imm,
             rd_data_a, rd_data_b, alu_result, alu_flags,
      input  req_ready, rd_en, rd_va, rd_vb, rd_beat, alu_opcode, alu_scalar, alu_a, alu_b, alu_c,
             wr_en, wr_vd, wr_beat, wr_data, wr_mask, busy, done, err, flags_out
   );
endinterface

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: runs one vector instruction beat by beat over LANES ALU lanes (read, execute, write back).
module vec_alu_sequencer #(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int VLEN  = 16,
   parameter int RAW   = 4
) (
   input logic clk,
   input logic rst_n,
   vec_alu_sequencer_if.master bus
);
   localparam int BEATS = VLEN / LANES;
   localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
   typedef enum logic [2:0] {IDLE, RD, EX, WB, DONE} state_t;
   state_t state, state_nx;
   logic [2:0] opcode;
   logic scalar, accept, bad_in, set_in, is_set, last, err;
   logic [RAW-1:0] vd, va, vb;
   logic [WIDTH-1:0] imm;
   logic [BW-1:0] beat;
   logic [LANES*WIDTH-1:0] wdata;
   logic [LANES-1:0] vmask;
   logic [3:0] acc, acc_nx, flags;
   assign accept = bus.req_valid && state == IDLE;
   assign bad_in = !(bus.req_opcode inside {3'b000, 3'b001, 3'b010, 3'b111});
   assign set_in = bus.req_opcode == 3'b111;
   assign is_set = opcode == 3'b111;
   assign last = scalar || beat == BW'(BEATS - 1);
   assign vmask = scalar ? LANES'(1) : {LANES{1'b1}};
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.req_valid) state_nx = bad_in ? DONE : set_in ? EX : RD;
         RD: state_nx = EX;
         EX: state_nx = WB;
         WB: state_nx = last ? DONE : is_set ? EX : RD;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // Lanes outside the mask never reach the accumulators, so their X flags cannot leak.
   always_comb begin
      acc_nx = acc;
      for (int i = 0; i < LANES; i++)
         if (vmask[i]) begin
            acc_nx[0] = acc_nx[0] | bus.alu_flags[i*4];
            acc_nx[1] = acc_nx[1] & bus.alu_flags[i*4+1];
            acc_nx[2] = acc_nx[2] | bus.alu_flags[i*4+2];
            acc_nx[3] = acc_nx[3] | bus.alu_flags[i*4+3];
         end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         opcode <= '0;
         scalar <= 1'b0;
         vd <= '0;
         va <= '0;
         vb <= '0;
         imm <= '0;
         beat <= '0;
         wdata <= '0;
         acc <= '0;
         flags <= '0;
         err <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            opcode <= bus.req_opcode;
            scalar <= bus.req_scalar;
            vd <= bus.req_vd;
            va <= bus.req_va;
            vb <= bus.req_vb;
            imm <= bus.req_imm;
            beat <= '0;
            acc <= 4'b0010;
         end
         if (state == EX) begin
            wdata <= bus.alu_result;
            acc <= acc_nx;
         end
         if (state == WB && !last) beat <= beat + 1'b1;
         if (accept && bad_in) begin
            flags <= '0;
            err <= 1'b1;
         end else if (state == WB && last) begin
            flags <= acc;
            err <= 1'b0;
         end
      end
   assign bus.req_ready = state == IDLE;
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   assign bus.err = err;
   assign bus.flags_out = flags;
   assign bus.rd_en = state == RD;
   assign bus.rd_va = va;
   assign bus.rd_vb = vb;
   assign bus.rd_beat = beat;
   assign bus.alu_opcode = opcode;
   assign bus.alu_scalar = scalar;
   assign bus.alu_a = state == EX ? bus.rd_data_a : '0;
   assign bus.alu_b = state == EX ? bus.rd_data_b : '0;
   assign bus.alu_c = {LANES{imm}};
   assign bus.wr_en = state == WB;
   assign bus.wr_vd = vd;
   assign bus.wr_beat = beat;
   assign bus.wr_data = wdata;
   assign bus.wr_mask = state == WB ? vmask : '0;
endmodule

// File: doc/vec_alu_sequencer.md
# vec_alu_sequencer

Multi-beat controller that runs one vector instruction over a bank of `LANES` physical ALU lanes. It reads operand slices from the vector register file, drives the lanes' opcode, scalar flag and operands, captures results, and writes them back beat by beat. It also folds per-lane flags into one instruction-level flag nibble. It sits between instruction decode and the vector datapath.

## Interface
- `WIDTH`, 8, element width in bits
- `LANES`, 4, physical ALU lanes; power of two
- `VLEN`, 16, elements per vector; multiple of `LANES`; `BEATS = VLEN/LANES`
- `RAW`, 4, register-index width
- `clk` in 1: the block's single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1, `req_ready` out 1: instruction handshake; a request is accepted when both are 1.
- `req_opcode` in 3: 000 mul, 001 sub, 010 add, 111 set; all other values are invalid.
- `req_scalar` in 1: scalar operation, lane 0 / element 0 only.
- `req_vd`, `req_va`, `req_vb` in RAW: destination and source register indices.
- `req_imm` in WIDTH: set value, broadcast to every lane's `c` operand.
- `rd_en` out 1, `rd_va`/`rd_vb` out RAW, `rd_beat` out $clog2(BEATS)$: register-file read; data returns 1 cycle later.
- `rd_data_a`, `rd_data_b` in LANES*WIDTH: operand slices; lane i is bits [i*WIDTH +: WIDTH].
- `alu_opcode` out 3, `alu_scalar` out 1, `alu_a`/`alu_b`/`alu_c` out LANES*WIDTH: lane drive signals.
- `alu_result` in LANES*WIDTH, `alu_flags` in LANES*4: combinational lane outputs; per-lane flag order is {V,N,Z,C}.
- `wr_en` out 1, `wr_vd` out RAW, `wr_beat` out, `wr_data` out LANES*WIDTH, `wr_mask` out LANES: register-file write port.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1, `flags_out` out 4.

## Operation
- FSM states: IDLE, RD, EX, WB, DONE.
- `req_ready` = 1 only in IDLE. On accept, opcode, scalar flag, indices and imm are latched and the beat counter is cleared.
- IDLE transitions on accept:
  - Valid opcode except set → RD.
  - Set → EX; set never reads the register file.
  - Invalid opcode → DONE with `err` = 1 and no reads or writes.
- RD: assert `rd_en` for the current beat. Always → EX.
- EX:
  - Drive `alu_a`/`alu_b` from `rd_data_*`, `alu_c` = imm replicated per lane.
  - Register `alu_result` into the write-data register.
  - Fold flags of the valid lanes into the accumulators. Valid lanes are all lanes, or lane 0 only when scalar.
  - Always → WB.
- WB: assert `wr_en` with `wr_beat` = beat. `wr_mask` = all ones, or 0…01 when scalar.
  - Last beat → DONE. Scalar always has exactly 1 beat.
  - Otherwise increment beat, then → RD, or → EX for set.
- DONE: pulse `done` and load `flags_out` from the accumulators. Always → IDLE.
- Flag fold across all valid elements of the instruction:
  - C = OR
  - Z = AND (true only if every result is zero)
  - N = OR
  - V = OR
- Accumulators reset at accept: C/N/V = 0, Z = 1.
- Flags from lanes outside the mask are ignored; they may be X.
- `alu_opcode` and `alu_scalar` hold their latched values from accept until the next accept.
- `flags_out` and `err` hold until the next DONE. `err` = 0 for valid opcodes.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset values:
  - FSM = IDLE, `req_ready` = 1.
  - `busy`, `done`, `err`, `rd_en`, `wr_en` = 0.
  - `flags_out` = 0, `wr_mask` = 0, beat = 0.
  - All data and address outputs = 0.
- Latency from an accept in cycle T to `done`:
  - Read ops: `done` in cycle T + 3*BEATS + 1.
  - Set: T + 2*BEATS + 1.
  - Scalar read op: T + 4. Scalar set: T + 3.
  - Invalid opcode: T + 1.
- Write k lands in WB for beat k; beats are written strictly in ascending order.
- Because `req_ready` = 0 in DONE, back-to-back requests are accepted one cycle after `done`. A request held by `req_valid` is accepted on the first IDLE cycle.
- Reset asserted mid-instruction: the block returns immediately to IDLE. No further `wr_en`, no `done`, and `flags_out` is cleared.
- The register file must not be written by others between an instruction's RD and WB. Enforcing this is upstream's responsibility; the sequencer does no hazard checking.

## Test plan
- Vector add (LANES=4, VLEN=16), va all 0x7F, vb all 0x01:
  - 4 writes of 0x80 per element.
  - `done` at T+13 with `flags_out` = V1 N1 Z0 C0.
- Scalar mul, a[0] = 0x10, b[0] = 0x10, other lanes driven X:
  - Single write with `wr_mask` = 0001, result 0x00.
  - `flags_out` = V1 Z1 N0 C0, `done` at T+4.
  - No X propagates into `flags_out`.
- Vector set with imm 0x00:
  - No `rd_en` ever.
  - 4 writes of zeros, `flags_out` Z=1, `done` at T+9.
- Opcode 011:
  - `done` at T+1 with `err` = 1.
  - `rd_en` and `wr_en` never asserted; `flags_out` = 0.
- `rst_n` pulsed low during WB of beat 1 of a vector sub:
  - No further writes, no `done`.
  - `req_ready` = 1 immediately, `flags_out` = 0.
- Two requests with `req_valid` held high (sub then add):
  - Second accept occurs exactly one cycle after the first `done`.
  - Each `done` carries its own flags; the accumulators do not leak between instructions.
